ahb_rr_arbiter: RTL and testbench
=================================

# ahb_rr_arbiter

Parametrised round-robin AHB bus arbiter for the multi-manager interconnect. It selects one of MANAGERS requesters and drives a registered one-hot grant to the address/control muxes. The grant is handed over only at legal AHB transfer boundaries. It holds ownership through locked sequences and, optionally, through fixed-length bursts. With no requests pending, the bus parks on a default manager.

## Interface
- MANAGERS, 4: number of requesting managers, ≥2.
- DEFAULT_MGR, 0: manager parked on when no requests; also the reset owner.
- IDW, $clog2(MANAGERS): width of the grant index.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  MANAGERS  bus request, bit i = manager i.
- lock  in  MANAGERS  HMASTLOCK request, bit i = manager i.
- htrans  in  2  HTRANS of the current owner (post-mux).
- hburst  in  3  HBURST of the current owner (post-mux).
- hready  in  1  bus HREADY.
- grant  out  MANAGERS  one-hot owner vector; never zero.
- grant_id  out  IDW  binary index of the owner.
- mastlock  out  1  registered lock of the current owner.

## Operation
- States:
  - PARK: no owner requesting.
  - OWN: normal ownership.
  - BURST: fixed-length burst in progress.
  - LOCKED: locked sequence in progress.
- Handover point: hready=1 and state is not LOCKED and not BURST.
- At a handover point the arbiter picks a new owner:
  - Search req in rotating order starting at ptr+1 and wrapping modulo MANAGERS. The current owner is considered last.
  - If a requester is found: grant it, set ptr to its index, and go to OWN.
  - If no requester is found: grant DEFAULT_MGR and go to PARK. ptr is unchanged.
- Entry to LOCKED: at a handover point, if lock[grant_id]=1 and htrans≠IDLE, enter LOCKED and keep the current grant (no rotation).
- Exit from LOCKED: on a cycle with hready=1, lock[grant_id]=0 and htrans=IDLE, go to OWN. That same cycle counts as a handover point.
- req and lock of non-owners are ignored while LOCKED or BURST.
- mastlock: registered copy of lock[grant_id], updated only when hready=1.
- htrans=BUSY: treated as neither a beat nor IDLE. Ownership is held.
- Simultaneous lock entry and burst start: LOCKED takes precedence. The beat counter still runs, but it does not affect the exit from LOCKED.

## Timing
- Reset values: grant = one-hot DEFAULT_MGR, grant_id = DEFAULT_MGR, mastlock=0, ptr=DEFAULT_MGR, state PARK, beats_left=0.
- Latency: a decision made at a handover point in cycle N is visible on grant/grant_id in cycle N+1. This lines up with the AHB address phase of the new owner.
- hready=0: grant, ptr, state and beat count are all frozen.
- Reset asserted mid-burst or mid-lock: outputs return to reset values asynchronously. No partial state is retained.
- Starvation bound: while unlocked, a continuously requesting manager is granted within MANAGERS−1 handover points.

## Configuration
- ARB_BURST_HOLD_EN defined:
  - A NONSEQ with hready=1 and hburst ∈ {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} loads beats_left = length−1 and enters BURST.
  - Each SEQ with hready=1 decrements beats_left.
  - Reaching 0, or an IDLE/NONSEQ (early termination), returns the state to OWN.
  - SINGLE and INCR never enter BURST.
- ARB_BURST_HOLD_EN undefined: the BURST state and beat counter are absent. Every hready=1 cycle outside LOCKED is a handover point.

## Structure
- Package ahb_arb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hburst_t enum (the 8 AHB encodings).
  - arb_state_t enum.
  - Function burst_len(hburst_t) returning 1/4/8/16.
- Sub-module rr_pick: combinational rotating priority select. Inputs: req, ptr, current owner. Outputs: valid, index, one-hot.
- All sequential logic (state, ptr, grant, beat counter, mastlock) lives in ahb_rr_arbiter.

## Test plan
- Reset with req=0000 → grant=0001, grant_id=0, mastlock=0. Grant remains 0001 for 10 idle cycles.
- req=1111, NONSEQ SINGLE every cycle, hready=1 → grant_id sequence 1,2,3,0,1, one change per cycle.
- ARB_BURST_HOLD_EN on; mgr 1 issues INCR4 with req=1111 and 2 hready=0 wait states inside the burst → grant held on mgr 1 for 4 beats plus 2 waits, then moves to 2. With the macro off → grant moves after the first beat.
- Mgr 2 asserts lock for 3 NONSEQ transfers with req=1111 → grant_id=2 and mastlock=1 throughout. Release happens only after lock=0 and htrans=IDLE with hready=1, then grant_id=3.
- hready held 0 for 5 cycles while req changes → grant and grant_id unchanged. On the first hready=1 cycle, arbitration occurs and the new grant appears the next cycle.
- Assert rst_n low mid-INCR8 on mgr 3 → grant=0001 immediately. After release the bus is in PARK and the first requester is granted per the order starting at index 1.

Source files
------------

// File: rtl/ahb_rr_arbiter_pkg.sv
// Shared types for the AHB round-robin arbiter: transfer/burst encodings and arbiter states.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ahb_arb_pkg;

  // AHB HTRANS encodings
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  // AHB HBURST encodings
  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    PARK   = 2'b00,
    OWN    = 2'b01,
    BURST  = 2'b10,
    LOCKED = 2'b11
  } arb_state_t;

  // Wide enough to hold the remaining beats of the longest fixed burst (16-1)
  localparam int BEAT_W = 4;

  // Number of beats in a burst; undefined-length bursts count as 1
  function automatic logic [4:0] burst_len(hburst_t b);
    case (b)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter_if.sv
// Bus-side signals between the managers' post-mux control and the arbiter.
// Latency: none, wires only.
// Backpressure: HREADY travels through this bundle; the arbiter freezes when it is low.
interface ahb_rr_arbiter_if #(
  parameter int MANAGERS = 4,
  parameter int IDW      = $clog2(MANAGERS)
);
  import ahb_arb_pkg::*;

  logic [MANAGERS-1:0] req;
  logic [MANAGERS-1:0] lock;
  htrans_t             htrans;
  hburst_t             hburst;
  logic                hready;
  logic [MANAGERS-1:0] grant;
  logic [IDW-1:0]      grant_id;
  logic                mastlock;

  // Requesting/bus side
  modport master (
    output req, lock, htrans, hburst, hready,
    input  grant, grant_id, mastlock
  );

  // Arbiter side
  modport slave (
    input  req, lock, htrans, hburst, hready,
    output grant, grant_id, mastlock
  );

endinterface

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// Rotating-priority requester select: search starts after ptr, current owner is tried last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_pick #(
  parameter int MANAGERS = 4,
  parameter int IDW      = $clog2(MANAGERS)
) (
  input  logic [MANAGERS-1:0] req_i,
  input  logic [IDW-1:0]      ptr_i,
  input  logic [IDW-1:0]      owner_i,
  output logic                vld_o,
  output logic [IDW-1:0]      idx_o,
  output logic [MANAGERS-1:0] onehot_o
);

  // First requester in order ptr+1, ptr+2, ... (mod MANAGERS), skipping the owner until the end
  always_comb begin
    logic [IDW-1:0] cand;
    vld_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = '0;
    for (int k = 1; k <= MANAGERS; k++) begin
      cand = IDW'((int'(ptr_i) + k) % MANAGERS);
      if (!vld_o && (cand != owner_i) && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    if (!vld_o && req_i[owner_i]) begin
      vld_o = 1'b1;
      idx_o = owner_i;
    end
    if (vld_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, handover only at legal transfer boundaries.
// Latency: decision at a handover point in cycle N appears on grant/grant_id in cycle N+1.
// Backpressure: hready=0 freezes all state. Define ARB_BURST_HOLD_EN to hold the grant over fixed bursts.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MANAGERS    = 4,
  parameter int DEFAULT_MGR = 0,
  parameter int IDW         = $clog2(MANAGERS)
) (
  input logic          clk,
  input logic          rst_n,
  ahb_rr_arbiter_if.slave bus
);

  localparam logic [IDW-1:0]      DEF_ID = IDW'(DEFAULT_MGR);
  localparam logic [MANAGERS-1:0] DEF_OH = {{(MANAGERS-1){1'b0}}, 1'b1} << DEFAULT_MGR;

  arb_state_t          state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [MANAGERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic                mastlock_q, mastlock_d;
  logic                handover;
  logic                owner_lock;

  logic                pick_vld;
  logic [IDW-1:0]      pick_idx;
  logic [MANAGERS-1:0] pick_oh;

`ifdef ARB_BURST_HOLD_EN
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic                fixed_burst;
  assign fixed_burst = (burst_len(bus.hburst) != 5'd1);
`else
  // Burst type only matters when burst hold is built in
  logic                hburst_unused;
  assign hburst_unused = ^bus.hburst;
`endif

  assign owner_lock = bus.lock[gid_q];

  rr_pick #(
    .MANAGERS (MANAGERS),
    .IDW      (IDW)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .owner_i  (gid_q),
    .vld_o    (pick_vld),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  // Next-state: find handover points, then lock / burst hold / rotate / park
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    gid_d      = gid_q;
    mastlock_d = mastlock_q;
    handover   = 1'b0;
`ifdef ARB_BURST_HOLD_EN
    beats_d    = beats_q;
`endif
    if (bus.hready) begin
      mastlock_d = owner_lock;

`ifdef ARB_BURST_HOLD_EN
      // Beat counter runs on every completed beat, including inside locked sequences
      case (bus.htrans)
        NONSEQ:  beats_d = BEAT_W'(burst_len(bus.hburst) - 5'd1);
        SEQ:     if (beats_q != '0) beats_d = beats_q - 1'b1;
        IDLE:    beats_d = '0;
        default: ;
      endcase
`endif

      case (state_q)
        LOCKED:  handover = !owner_lock && (bus.htrans == IDLE);
`ifdef ARB_BURST_HOLD_EN
        // Last SEQ beat or an early termination releases the burst hold
        BURST:   handover = (bus.htrans == IDLE) || (bus.htrans == NONSEQ) ||
                            ((bus.htrans == SEQ) && (beats_q == BEAT_W'(1)));
`endif
        default: handover = 1'b1;
      endcase

      if (handover) begin
        if (owner_lock && (bus.htrans != IDLE)) begin
          state_d = LOCKED;
`ifdef ARB_BURST_HOLD_EN
        end else if ((bus.htrans == NONSEQ) && fixed_burst) begin
          state_d = BURST;
`endif
        end else if (pick_vld) begin
          state_d = OWN;
          ptr_d   = pick_idx;
          gid_d   = pick_idx;
          grant_d = pick_oh;
        end else begin
          state_d = PARK;
          gid_d   = DEF_ID;
          grant_d = DEF_OH;
        end
      end
    end
  end

  // State registers; reset parks on the default manager
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PARK;
      ptr_q      <= DEF_ID;
      grant_q    <= DEF_OH;
      gid_q      <= DEF_ID;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
      mastlock_q <= mastlock_d;
    end
  end

`ifdef ARB_BURST_HOLD_EN
  // Remaining beats of the fixed-length burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
    end else begin
      beats_q <= beats_d;
    end
  end
`endif

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.mastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Testbench for ahb_rr_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: model advances on each rising edge; DUT is sampled 1ns later.
// Backpressure: hready is driven randomly and in directed freeze windows.
module tb_ahb_rr_arbiter;
  import ahb_arb_pkg::*;

  localparam int M   = 4;
  localparam int DEF = 0;
`ifdef ARB_BURST_HOLD_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb_rr_arbiter_if #(.MANAGERS(M)) bus ();

  ahb_rr_arbiter #(
    .MANAGERS    (M),
    .DEFAULT_MGR (DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner;   // who holds the bus
  int m_last;    // last manager won through arbitration
  bit m_locked;
  bit m_burst;
  int m_beats;
  bit m_mlock;

  function automatic void model_reset();
    m_owner  = DEF;
    m_last   = DEF;
    m_locked = 1'b0;
    m_burst  = 1'b0;
    m_beats  = 0;
    m_mlock  = 1'b0;
  endfunction

  function automatic bit bit_at(logic [M-1:0] v, int i);
    logic [M-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic int blen(logic [2:0] hb);
    if (hb < 3'd2) return 1;
    if (hb < 3'd4) return 4;
    if (hb < 3'd6) return 8;
    return 16;
  endfunction

  function automatic void model_clock(logic [M-1:0] rq, logic [M-1:0] lk, logic [1:0] ht,
                                      logic [2:0] hb, bit hr);
    bit olk;
    bit hand;
    int nb;
    int best;
    int bestd;
    int d;
    if (!hr) return;
    olk = bit_at(lk, m_owner);
    nb  = m_beats;
    if (ht == 2'd2) nb = blen(hb) - 1;
    else if (ht == 2'd3 && m_beats > 0) nb = m_beats - 1;
    else if (ht == 2'd0) nb = 0;

    if (m_locked)     hand = !olk && (ht == 2'd0);
    else if (m_burst) hand = (ht == 2'd0) || (ht == 2'd2) || (ht == 2'd3 && m_beats == 1);
    else              hand = 1'b1;

    m_mlock = olk;
    if (hand) begin
      if (olk && ht != 2'd0) begin
        m_locked = 1'b1;
        m_burst  = 1'b0;
      end else if (BURST_EN && ht == 2'd2 && blen(hb) > 1) begin
        m_locked = 1'b0;
        m_burst  = 1'b1;
      end else begin
        m_locked = 1'b0;
        m_burst  = 1'b0;
        // distance after the last winner; the current owner ranks behind everyone
        best  = -1;
        bestd = M + 1;
        for (int c = 0; c < M; c++) begin
          if (bit_at(rq, c)) begin
            d = (c == m_owner) ? M : ((c - m_last - 1 + 2 * M) % M);
            if (d < bestd) begin
              bestd = d;
              best  = c;
            end
          end
        end
        if (best >= 0) begin
          m_owner = best;
          m_last  = best;
        end else begin
          m_owner = DEF;
        end
      end
    end
    m_beats = nb;
  endfunction

  task automatic cmp_model(input string tag);
    chk_eq({tag, "/grant_id"}, 32'(bus.grant_id), 32'(m_owner));
    chk_eq({tag, "/grant"},    32'(bus.grant),    32'(1) << m_owner);
    chk_eq({tag, "/mastlock"}, 32'(bus.mastlock), 32'(m_mlock));
  endtask

  // Drive one cycle of inputs, clock it into DUT and model, then compare
  task automatic cycle(input logic [M-1:0] rq, input logic [M-1:0] lk, input logic [1:0] ht,
                       input logic [2:0] hb, input bit hr, input string tag);
    bus.req    = rq;
    bus.lock   = lk;
    bus.htrans = htrans_t'(ht);
    bus.hburst = hburst_t'(hb);
    bus.hready = hr;
    @(posedge clk);
    model_clock(rq, lk, ht, hb, hr);
    #1;
    cmp_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int exp_burst[6];
    int exp_rr[5];
    logic [1:0] ht;
    int r;

    bus.req    = '0;
    bus.lock   = '0;
    bus.htrans = IDLE;
    bus.hburst = SINGLE;
    bus.hready = 1'b1;
    rst_n      = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("reset/grant",    32'(bus.grant),    32'h1);
    chk_eq("reset/grant_id", 32'(bus.grant_id), 32'h0);
    chk_eq("reset/mastlock", 32'(bus.mastlock), 32'h0);
    #9 rst_n = 1'b1;

    // Parked bus stays on the default manager
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, "idle");
      chk_eq("idle/park", 32'(bus.grant), 32'h1);
    end

    // All requesting, single transfers: strict rotation from index 1
    exp_rr = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, "rr");
      chk_eq("rr/seq", 32'(bus.grant_id), 32'(exp_rr[i]));
    end

    // Manager 1 INCR4 with two wait states inside the burst
`ifdef ARB_BURST_HOLD_EN
    exp_burst = '{1, 1, 1, 1, 1, 2};
`else
    exp_burst = '{2, 3, 3, 3, 0, 1};
`endif
    cycle(4'b1111, 4'b0000, 2'd2, 3'd3, 1'b1, "burst");
    chk_eq("burst/b0", 32'(bus.grant_id), 32'(exp_burst[0]));
    cycle(4'b1111, 4'b0000, 2'd3, 3'd3, 1'b1, "burst");
    chk_eq("burst/b1", 32'(bus.grant_id), 32'(exp_burst[1]));
    cycle(4'b1111, 4'b0000, 2'd3, 3'd3, 1'b0, "burst");
    chk_eq("burst/w0", 32'(bus.grant_id), 32'(exp_burst[2]));
    cycle(4'b1111, 4'b0000, 2'd3, 3'd3, 1'b0, "burst");
    chk_eq("burst/w1", 32'(bus.grant_id), 32'(exp_burst[3]));
    cycle(4'b1111, 4'b0000, 2'd3, 3'd3, 1'b1, "burst");
    chk_eq("burst/b2", 32'(bus.grant_id), 32'(exp_burst[4]));
    cycle(4'b1111, 4'b0000, 2'd3, 3'd3, 1'b1, "burst");
    chk_eq("burst/b3", 32'(bus.grant_id), 32'(exp_burst[5]));

    // Manager 2 locked sequence
    cycle(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, "lock");
    chk_eq("lock/take", 32'(bus.grant_id), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 4'b0100, 2'd2, 3'd0, 1'b1, "lock");
      chk_eq("lock/hold_id", 32'(bus.grant_id), 32'd2);
      chk_eq("lock/mastlock", 32'(bus.mastlock), 32'd1);
    end
    cycle(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, "lock");
    chk_eq("lock/no_idle_hold", 32'(bus.grant_id), 32'd2);
    cycle(4'b1111, 4'b0000, 2'd0, 3'd0, 1'b1, "lock");
    chk_eq("lock/release", 32'(bus.grant_id), 32'd3);

    // hready low freezes arbitration while requests churn
    for (int i = 0; i < 5; i++) begin
      cycle(4'($urandom), 4'b0000, 2'($urandom), 3'd0, 1'b0, "freeze");
      chk_eq("freeze/grant_id", 32'(bus.grant_id), 32'd3);
    end
    cycle(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, "freeze");
    chk_eq("freeze/resume", 32'(bus.grant_id), 32'd1);

    // Async reset in the middle of an INCR8 on manager 3
    cycle(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, "rst");
    chk_eq("rst/take3", 32'(bus.grant_id), 32'd3);
    cycle(4'b1000, 4'b0000, 2'd2, 3'd5, 1'b1, "rst");
    cycle(4'b1111, 4'b0000, 2'd3, 3'd5, 1'b1, "rst");
    cycle(4'b1111, 4'b0000, 2'd3, 3'd5, 1'b1, "rst");
    #3 rst_n = 1'b0;
    #1;
    chk_eq("rst/grant",    32'(bus.grant),    32'h1);
    chk_eq("rst/grant_id", 32'(bus.grant_id), 32'h0);
    chk_eq("rst/mastlock", 32'(bus.mastlock), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    cycle(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, "rst");
    chk_eq("rst/first_pick", 32'(bus.grant_id), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      ht = 2'd0;
      else if (r < 4) ht = 2'd1;
      else if (r < 7) ht = 2'd2;
      else            ht = 2'd3;
      cycle(4'($urandom),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
            ht,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0),
            "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
